// File: rtl/blackjack_ctrl.sv
// Blackjack round sequencer: deals cards over a valid/req handshake, drives the sum unit and keeps scores.
// Control pulses are Moore-decoded from state; card transfers stall indefinitely while card_valid is low.
module blackjack_ctrl #(
    parameter int CARD_LIMIT = 5,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hit,
    input  logic             stand,
    input  logic             card_valid,
    input  logic [3:0]       card_in,
    output logic             card_req,
    output logic             card_err,
    output logic [3:0]       card_value,
    output logic             clear_sums,
    output logic             deal_player,
    output logic             deal_dealer,
    output logic             compare,
    input  logic             player_bust,
    input  logic             dealer_auto_hit,
    input  logic             player_win,
    input  logic             dealer_win,
    input  logic             tie,
    output logic             busy,
    output logic             player_turn,
    output logic [2:0]       player_cards,
    output logic             result_valid,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] player_wins,
    output logic [CNT_W-1:0] dealer_wins,
    output logic [CNT_W-1:0] ties
);

    typedef enum logic [4:0] {
        IDLE, CLEAR,
        REQ_P1, DEAL_P1, REQ_D1, DEAL_D1,
        REQ_P2, DEAL_P2, REQ_D2, DEAL_D2,
        PLAYER_TURN, REQ_PH, DEAL_PH,
        DEALER_TURN, REQ_DH, DEAL_DH,
        COMPARE, RESULT
    } state_t;

    localparam logic [2:0] LIMIT = 3'(CARD_LIMIT);

    state_t             state_q, state_d;
    logic [3:0]         card_value_q;
    logic               card_err_q;
    logic [2:0]         player_cards_q;
    logic [1:0]         result_q;
    logic [CNT_W-1:0]   player_wins_q, dealer_wins_q, ties_q;

    logic xfer, legal, take, reject, idle_like;

    assign xfer      = card_req && card_valid;
    assign legal     = (card_in >= 4'd1) && (card_in <= 4'd11);
    assign take      = xfer && legal;
    assign reject    = xfer && !legal;
    assign idle_like = (state_q == IDLE) || (state_q == RESULT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESULT: if (start) state_d = CLEAR;
            CLEAR:        state_d = REQ_P1;
            REQ_P1:       if (take) state_d = DEAL_P1;
            DEAL_P1:      state_d = REQ_D1;
            REQ_D1:       if (take) state_d = DEAL_D1;
            DEAL_D1:      state_d = REQ_P2;
            REQ_P2:       if (take) state_d = DEAL_P2;
            DEAL_P2:      state_d = REQ_D2;
            REQ_D2:       if (take) state_d = DEAL_D2;
            DEAL_D2:      state_d = PLAYER_TURN;
            // Bust ends the round at once; a hit beyond the limit falls through to stand.
            PLAYER_TURN: begin
                if (player_bust)                     state_d = COMPARE;
                else if (hit && player_cards_q < LIMIT) state_d = REQ_PH;
                else if (stand)                      state_d = DEALER_TURN;
            end
            REQ_PH:       if (take) state_d = DEAL_PH;
            DEAL_PH:      state_d = PLAYER_TURN;
            DEALER_TURN:  state_d = dealer_auto_hit ? REQ_DH : COMPARE;
            REQ_DH:       if (take) state_d = DEAL_DH;
            DEAL_DH:      state_d = DEALER_TURN;
            COMPARE:      state_d = RESULT;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        card_req     = 1'b0;
        clear_sums   = 1'b0;
        deal_player  = 1'b0;
        deal_dealer  = 1'b0;
        compare      = 1'b0;
        case (state_q)
            REQ_P1, REQ_D1, REQ_P2, REQ_D2, REQ_PH, REQ_DH: card_req = 1'b1;
            CLEAR:                     clear_sums  = 1'b1;
            DEAL_P1, DEAL_P2, DEAL_PH: deal_player = 1'b1;
            DEAL_D1, DEAL_D2, DEAL_DH: deal_dealer = 1'b1;
            COMPARE:                   compare     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            card_value_q   <= '0;
            card_err_q     <= 1'b0;
            player_cards_q <= '0;
            result_q       <= '0;
            player_wins_q  <= '0;
            dealer_wins_q  <= '0;
            ties_q         <= '0;
        end else begin
            state_q    <= state_d;
            card_err_q <= reject;
            if (take)
                card_value_q <= card_in;
            if (idle_like && start)
                player_cards_q <= '0;
            else if (deal_player)
                player_cards_q <= player_cards_q + 3'd1;
            if (compare) begin
                if (player_win) begin
                    result_q <= 2'b01;
                    if (player_wins_q != '1) player_wins_q <= player_wins_q + 1'b1;
                end else if (dealer_win) begin
                    result_q <= 2'b10;
                    if (dealer_wins_q != '1) dealer_wins_q <= dealer_wins_q + 1'b1;
                end else if (tie) begin
                    result_q <= 2'b11;
                    if (ties_q != '1) ties_q <= ties_q + 1'b1;
                end else begin
                    result_q <= 2'b00;
                end
            end
        end
    end

    assign card_err     = card_err_q;
    assign card_value   = card_value_q;
    assign busy         = !idle_like;
    assign player_turn  = (state_q == PLAYER_TURN);
    assign player_cards = player_cards_q;
    assign result_valid = (state_q == RESULT);
    assign result       = result_q;
    assign player_wins  = player_wins_q;
    assign dealer_wins  = dealer_wins_q;
    assign ties         = ties_q;

endmodule

// File: tb/tb_blackjack_ctrl.sv
// Directed bench for blackjack_ctrl with a behavioural sum unit (no soft aces) and a card source.
module tb_blackjack_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, hit, stand, card_valid;
    logic [3:0] card_in;
    logic       card_req, card_err, clear_sums, deal_player, deal_dealer, compare;
    logic [3:0] card_value;
    logic       player_bust, dealer_auto_hit, player_win, dealer_win, tie;
    logic       busy, player_turn, result_valid;
    logic [2:0] player_cards;
    logic [1:0] result;
    logic [1:0] player_wins, dealer_wins, ties;

    blackjack_ctrl #(.CARD_LIMIT(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
        .card_valid(card_valid), .card_in(card_in), .card_req(card_req),
        .card_err(card_err), .card_value(card_value), .clear_sums(clear_sums),
        .deal_player(deal_player), .deal_dealer(deal_dealer), .compare(compare),
        .player_bust(player_bust), .dealer_auto_hit(dealer_auto_hit),
        .player_win(player_win), .dealer_win(dealer_win), .tie(tie),
        .busy(busy), .player_turn(player_turn), .player_cards(player_cards),
        .result_valid(result_valid), .result(result),
        .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    psum = 0, dsum = 0;
    int    cmp_pulses = 0, err_pulses = 0;
    string seq = "";
    int    n_cmp = 0, n_bad = 0;
    int    k0;

    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic unit stand-in: sums update on the edge that ends a deal cycle.
    always @(posedge clk) begin
        if (clear_sums) begin
            psum <= 0;
            dsum <= 0;
        end else if (deal_player) begin
            psum <= psum + int'(card_value);
        end else if (deal_dealer) begin
            dsum <= dsum + int'(card_value);
        end
    end

    assign player_bust     = psum > 21;
    assign dealer_auto_hit = dsum < 17;
    assign player_win      = (psum <= 21) && ((dsum > 21) || (psum > dsum));
    assign dealer_win      = (psum > 21) || ((dsum <= 21) && (dsum > psum));
    assign tie             = (psum <= 21) && (dsum <= 21) && (psum == dsum);

    always @(negedge clk) begin
        if (rst) begin
            if (deal_player)      seq <= {seq, "P"};
            else if (deal_dealer) seq <= {seq, "D"};
            if (compare)  cmp_pulses <= cmp_pulses + 1;
            if (card_err) err_pulses <= err_pulses + 1;
        end
    end

    logic [23:0] all_outs;
    assign all_outs = {card_req, card_err, card_value, clear_sums, deal_player, deal_dealer,
                       compare, busy, player_turn, player_cards, result_valid, result,
                       player_wins, dealer_wins, ties};

    task automatic wait_req(input string tag);
        int n = 0;
        @(negedge clk);
        while (!card_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!card_req) begin
            n_bad++;
            $display("FAIL %s: card_req never rose within 40 cycles", tag);
        end
    endtask

    task automatic wait_pt(input string tag);
        int n = 0;
        @(negedge clk);
        while (!player_turn && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!player_turn) begin
            n_bad++;
            $display("FAIL %s: player_turn never rose within 40 cycles", tag);
        end
    endtask

    task automatic wait_rv(input string tag);
        int n = 0;
        @(negedge clk);
        while (!result_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!result_valid) begin
            n_bad++;
            $display("FAIL %s: result_valid never rose within 60 cycles", tag);
        end
    endtask

    task automatic deliver(input logic [3:0] v);
        wait_req("deliver");
        card_valid = 1'b1;
        card_in    = v;
        @(posedge clk);
        #1;
        card_valid = 1'b0;
        card_in    = 4'd0;
    endtask

    task automatic deal4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        deliver(a);
        deliver(b);
        deliver(c);
        deliver(d);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k0 = cyc;
    endtask

    task automatic hit_stand(input logic h, input logic s);
        wait_pt("hit_stand");
        hit   = h;
        stand = s;
        @(posedge clk);
        #1;
        hit   = 1'b0;
        stand = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; hit = 1'b0; stand = 1'b0;
        card_valid = 1'b0; card_in = 4'd0;
        #12;
        n_cmp++;
        if (all_outs !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 000000", all_outs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b result_valid=%b want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_basic_round;
        int s0 = seq.len();
        int c0 = cmp_pulses;
        pulse_start;
        deal4(4'd10, 4'd5, 4'd9, 4'd7);
        wait_pt("basic_pt");
        // PLAYER_TURN is cycle k+10, i.e. nine edges after the start edge.
        n_cmp++;
        if (cyc - k0 != 9) begin
            n_bad++;
            $display("FAIL basic_latency: PLAYER_TURN %0d edges after start, want 9", cyc - k0);
        end
        hit_stand(1'b0, 1'b1);
        deliver(4'd6);
        wait_rv("basic_rv");
        n_cmp++;
        if (seq.substr(s0, seq.len() - 1) != "PDPDD") begin
            n_bad++;
            $display("FAIL basic_deal_order: got %s want PDPDD", seq.substr(s0, seq.len() - 1));
        end
        n_cmp++;
        if (cmp_pulses - c0 != 1) begin
            n_bad++;
            $display("FAIL basic_compare_count: got %0d want 1", cmp_pulses - c0);
        end
        n_cmp++;
        if (result !== 2'b01 || player_wins !== 2'd1 || result_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_result: result=%b pw=%0d rv=%b want 01 1 1",
                     result, player_wins, result_valid);
        end
    endtask

    task automatic test_bust;
        int s0 = seq.len();
        pulse_start;
        n_cmp++;
        if (result_valid !== 1'b0 || player_cards !== 3'd0) begin
            n_bad++;
            $display("FAIL bust_restart: rv=%b cards=%0d want 0 0", result_valid, player_cards);
        end
        deal4(4'd10, 4'd5, 4'd9, 4'd7);
        hit_stand(1'b1, 1'b0);
        deliver(4'd10);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (player_turn !== 1'b1) begin
            n_bad++;
            $display("FAIL bust_back_to_turn: player_turn=%b want 1", player_turn);
        end
        @(negedge clk);
        n_cmp++;
        if (compare !== 1'b1 || card_req !== 1'b0) begin
            n_bad++;
            $display("FAIL bust_direct_compare: compare=%b card_req=%b want 1 0", compare, card_req);
        end
        wait_rv("bust_rv");
        n_cmp++;
        if (seq.substr(s0, seq.len() - 1) != "PDPDP") begin
            n_bad++;
            $display("FAIL bust_deal_order: got %s want PDPDP", seq.substr(s0, seq.len() - 1));
        end
        n_cmp++;
        if (result !== 2'b10 || dealer_wins !== 2'd1 || player_cards !== 3'd3) begin
            n_bad++;
            $display("FAIL bust_result: result=%b dw=%0d cards=%0d want 10 1 3",
                     result, dealer_wins, player_cards);
        end
    endtask

    task automatic test_handshake;
        int e0 = err_pulses;
        pulse_start;
        wait_req("hs_p1");
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (card_req !== 1'b1 || deal_player !== 1'b0) begin
                n_bad++;
                $display("FAIL hs_stall%0d: card_req=%b deal_player=%b want 1 0", i, card_req, deal_player);
            end
            @(negedge clk);
        end
        card_valid = 1'b1;
        card_in    = 4'd0;
        @(posedge clk);
        #1;
        card_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (card_err !== 1'b1 || card_req !== 1'b1 || deal_player !== 1'b0) begin
            n_bad++;
            $display("FAIL hs_illegal: err=%b req=%b deal=%b want 1 1 0", card_err, card_req, deal_player);
        end
        @(negedge clk);
        n_cmp++;
        if (card_err !== 1'b0) begin
            n_bad++;
            $display("FAIL hs_err_one_cycle: card_err=%b want 0", card_err);
        end
        deliver(4'd8);
        @(negedge clk);
        n_cmp++;
        if (deal_player !== 1'b1 || card_value !== 4'd8) begin
            n_bad++;
            $display("FAIL hs_deal_p1: deal_player=%b card_value=%0d want 1 8", deal_player, card_value);
        end
        deliver(4'd5);
        deliver(4'd9);
        deliver(4'd7);
        hit_stand(1'b0, 1'b1);
        deliver(4'd6);
        wait_rv("hs_rv");
        n_cmp++;
        if (err_pulses - e0 != 1 || result !== 2'b10 || dealer_wins !== 2'd2) begin
            n_bad++;
            $display("FAIL hs_result: errs=%0d result=%b dw=%0d want 1 10 2",
                     err_pulses - e0, result, dealer_wins);
        end
    endtask

    task automatic test_card_limit;
        int s0 = seq.len();
        pulse_start;
        deal4(4'd2, 4'd3, 4'd2, 4'd10);
        hit_stand(1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (card_req !== 1'b1 || player_turn !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_hit_wins: card_req=%b player_turn=%b want 1 0", card_req, player_turn);
        end
        deliver(4'd2);
        wait_pt("limit_pt");
        n_cmp++;
        if (player_cards !== 3'd3) begin
            n_bad++;
            $display("FAIL limit_cards: got %0d want 3", player_cards);
        end
        hit_stand(1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (player_turn !== 1'b1 || card_req !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_hit_ignored: player_turn=%b card_req=%b want 1 0", player_turn, card_req);
        end
        hit_stand(1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (player_turn !== 1'b0 || card_req !== 1'b0 || busy !== 1'b1 || compare !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_dealer_turn: pt=%b req=%b busy=%b cmp=%b want 0 0 1 0",
                     player_turn, card_req, busy, compare);
        end
        deliver(4'd4);
        wait_rv("limit_rv");
        n_cmp++;
        if (seq.substr(s0, seq.len() - 1) != "PDPDPD" || result !== 2'b10 || dealer_wins !== 2'd3) begin
            n_bad++;
            $display("FAIL limit_result: seq=%s result=%b dw=%0d want PDPDPD 10 3",
                     seq.substr(s0, seq.len() - 1), result, dealer_wins);
        end
    endtask

    task automatic test_reset_mid_round;
        pulse_start;
        deal4(4'd2, 4'd3, 4'd2, 4'd10);
        hit_stand(1'b0, 1'b1);
        wait_req("mid_dh");
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (all_outs !== 24'd0) begin
            n_bad++;
            $display("FAIL mid_reset_async: got %h want 000000", all_outs);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start;
        @(negedge clk);
        n_cmp++;
        if (clear_sums !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_restart_clear: clear_sums=%b busy=%b want 1 1", clear_sums, busy);
        end
        deal4(4'd10, 4'd10, 4'd7, 4'd7);
        hit_stand(1'b0, 1'b1);
        wait_rv("mid_rv");
        n_cmp++;
        if (result !== 2'b11 || ties !== 2'd1 || player_wins !== 2'd0 || dealer_wins !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_clean_round: result=%b ties=%0d pw=%0d dw=%0d want 11 1 0 0",
                     result, ties, player_wins, dealer_wins);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            pulse_start;
            deal4(4'd10, 4'd10, 4'd7, 4'd7);
            hit_stand(1'b0, 1'b1);
            wait_rv("sat_rv");
            n_cmp++;
            if (result !== 2'b11 || ties !== 2'((r > 3) ? 3 : r)) begin
                n_bad++;
                $display("FAIL sat_round%0d: result=%b ties=%0d want 11 %0d",
                         r, result, ties, (r > 3) ? 3 : r);
            end
        end
        n_cmp++;
        if (player_wins !== 2'd0 || dealer_wins !== 2'd0) begin
            n_bad++;
            $display("FAIL sat_others: pw=%0d dw=%0d want 0 0", player_wins, dealer_wins);
        end
    endtask

    initial begin
        test_reset;
        test_basic_round;
        test_bust;
        test_handshake;
        test_card_limit;
        test_reset_mid_round;
        test_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
